// File: rtl/cpu_defs.sv
// ============================================================================
// cpu_defs : shared encodings for the EX-stage multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_defs;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_abs_neg.sv
// ============================================================================
// md_abs_neg : conditional two's-complement negate (magnitude and sign fixup)
// Rev 1.0
// ============================================================================
`default_nettype none

module md_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// ============================================================================
// hilo_muldiv : iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Rev 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv
  import cpu_defs::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  md_state_e          r_state, w_next;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_q, r_sign_r, r_yzero;
  logic               r_done, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_in_signed, w_in_div, w_op_div, w_accept, w_wb;
  logic [WIDTH-1:0]   w_xabs, w_yabs, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH+1:0]   w_trial, w_diff;
  logic               w_borrow;

  assign w_in_signed = (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);
  assign w_in_div    = (md_op_e'(op) == MD_DIV)  || (md_op_e'(op) == MD_DIVU);
  assign w_op_div    = (r_op == MD_DIV) || (r_op == MD_DIVU);
  assign w_accept    = (r_state == MD_IDLE) && start && !flush;
  assign w_wb        = (r_state == MD_FIX) && !flush;

  md_abs_neg #(.WIDTH(WIDTH)) u_xabs (
    .din(X), .en(w_in_signed && X[WIDTH-1]), .dout(w_xabs));
  md_abs_neg #(.WIDTH(WIDTH)) u_yabs (
    .din(Y), .en(w_in_signed && Y[WIDTH-1]), .dout(w_yabs));

  // Divide-by-zero keeps the all-ones quotient regardless of dividend sign
  md_abs_neg #(.WIDTH(2*WIDTH)) u_prod_fix (
    .din(r_acc), .en(r_sign_q), .dout(w_prod_fix));
  md_abs_neg #(.WIDTH(WIDTH)) u_quo_fix (
    .din(r_acc[WIDTH-1:0]), .en(r_sign_q && !r_yzero), .dout(w_quo_fix));
  md_abs_neg #(.WIDTH(WIDTH)) u_rem_fix (
    .din(r_rem[WIDTH-1:0]), .en(r_sign_r), .dout(w_rem_fix));

  // Multiply: multiplier sits in the low half and is consumed LSB first
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  // Divide: dividend sits in the low half and is consumed MSB first
  assign w_trial  = {r_rem, r_acc[WIDTH-1]};
  assign w_diff   = w_trial - {2'b00, r_b};
  assign w_borrow = w_diff[WIDTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (start && !flush) w_next = MD_CALC;
      MD_CALC: begin
        if (flush)                    w_next = MD_IDLE;
        else if (r_cnt == c_last_iter) w_next = MD_FIX;
      end
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MD_MULT;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_yzero  <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_wb;
      if (r_state == MD_IDLE) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
      if (w_accept) begin
        r_op     <= md_op_e'(op);
        r_a      <= w_xabs;
        r_b      <= w_yabs;
        r_acc    <= {{WIDTH{1'b0}}, (w_in_div ? w_xabs : w_yabs)};
        r_rem    <= '0;
        r_cnt    <= '0;
        r_sign_q <= w_in_signed && (X[WIDTH-1] ^ Y[WIDTH-1]);
        r_sign_r <= w_in_signed && X[WIDTH-1];
        r_yzero  <= w_in_div && (Y == '0);
        r_dz     <= 1'b0;
      end
      if (r_state == MD_CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_op_div) begin
          r_rem <= w_borrow ? w_trial[WIDTH:0] : w_diff[WIDTH:0];
          r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], ~w_borrow};
        end else begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
        end
      end
      if (w_wb) begin
        r_dz <= r_yzero;
        if (w_op_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign busy     = (r_state != MD_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire
